// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (column renderer, framebuffer read port, sync pads).
interface vga_timing_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int FRAME_W = 16
);
    logic               en;
    logic               restart;
    logic               pix_en;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  en, restart,
        output pix_en, x, y, active, hsync, vsync, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en, restart,
        input  pix_en, x, y, active, hsync, vsync, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock enable, x/y position,
// sync/active decode, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int FRAME_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_timing_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic             HS_IDLE  = ~HS_POL;
    localparam logic             VS_IDLE  = ~VS_POL;

    // Parameter sanity: counters must hold the full raster, porches must separate sync from wrap
    generate
        if (H_TOTAL > (2 ** X_W)) begin : g_bad_x_w
            $error("vga_timing_gen: H_TOTAL does not fit in X_W bits");
        end
        if (V_TOTAL > (2 ** Y_W)) begin : g_bad_y_w
            $error("vga_timing_gen: V_TOTAL does not fit in Y_W bits");
        end
        if (H_BP < 1 || V_BP < 1) begin : g_bad_bp
            $error("vga_timing_gen: H_BP and V_BP must be at least 1");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    function automatic logic decode_active(input logic [X_W-1:0] xv, input logic [Y_W-1:0] yv);
        return (xv < X_W'(H_ACTIVE)) && (yv < Y_W'(V_ACTIVE));
    endfunction

    function automatic logic decode_hsync(input logic [X_W-1:0] xv);
        return ((xv >= X_W'(HS_START)) && (xv < X_W'(HS_END))) ? HS_POL : HS_IDLE;
    endfunction

    function automatic logic decode_vsync(input logic [Y_W-1:0] yv);
        return ((yv >= Y_W'(VS_START)) && (yv < Y_W'(VS_END))) ? VS_POL : VS_IDLE;
    endfunction

    logic [DIV_W-1:0]   div_cnt_r;
    logic [DIV_W-1:0]   div_next_s;
    logic               tick_s;
    logic [X_W-1:0]     x_r;
    logic [X_W-1:0]     x_next_s;
    logic [Y_W-1:0]     y_r;
    logic [Y_W-1:0]     y_next_s;
    logic               frame_wrap_s;
    logic               pix_en_r;
    logic               active_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               line_start_r;
    logic               frame_start_r;
    logic [FRAME_W-1:0] frame_cnt_r;

    // Divider: the pixel strobe fires on the edge that lands the count on its last value
    always_comb begin
        div_next_s = div_cnt_r;
        if (div_cnt_r == DIV_LAST) begin
            div_next_s = {DIV_W{1'b0}};
        end else begin
            div_next_s = div_cnt_r + DIV_W'(1);
        end
        tick_s = (div_next_s == DIV_LAST);
    end

    // Next raster position; y only moves when x wraps
    always_comb begin
        x_next_s     = x_r;
        y_next_s     = y_r;
        frame_wrap_s = 1'b0;
        if (x_r == X_LAST) begin
            x_next_s = {X_W{1'b0}};
            if (y_r == Y_LAST) begin
                y_next_s     = {Y_W{1'b0}};
                frame_wrap_s = 1'b1;
            end else begin
                y_next_s = y_r + Y_W'(1);
            end
        end else begin
            x_next_s = x_r + X_W'(1);
        end
    end

    // Timing state: restart beats en and discards a coincident pixel advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            pix_en_r      <= 1'b0;
            x_r           <= X_LAST;
            y_r           <= Y_LAST;
            active_r      <= 1'b0;
            hsync_r       <= HS_IDLE;
            vsync_r       <= VS_IDLE;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= {FRAME_W{1'b0}};
        end else if (bus.restart) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            pix_en_r      <= 1'b0;
            x_r           <= X_LAST;
            y_r           <= Y_LAST;
            active_r      <= 1'b0;
            hsync_r       <= HS_IDLE;
            vsync_r       <= VS_IDLE;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (bus.en) begin
            div_cnt_r <= div_next_s;
            pix_en_r  <= tick_s;
            if (tick_s) begin
                x_r           <= x_next_s;
                y_r           <= y_next_s;
                active_r      <= decode_active(x_next_s, y_next_s);
                hsync_r       <= decode_hsync(x_next_s);
                vsync_r       <= decode_vsync(y_next_s);
                line_start_r  <= (x_r == X_LAST);
                frame_start_r <= frame_wrap_s;
                if (frame_wrap_s) begin
                    frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
                end else begin
                    frame_cnt_r <= frame_cnt_r;
                end
            end else begin
                line_start_r  <= 1'b0;
                frame_start_r <= 1'b0;
            end
        end else begin
            pix_en_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign bus.pix_en      = pix_en_r;
    assign bus.x           = x_r;
    assign bus.y           = y_r;
    assign bus.active      = active_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.line_start  = line_start_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small raster with CLK_DIV=2 (dut1) and
// CLK_DIV=1 with a 2-bit frame counter (dut2), checked against a pixel-count model.
module tb_vga_timing_gen;
    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int D1 = 2;
    localparam int D2 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_if #(.X_W(4), .Y_W(3), .FRAME_W(16)) bus1 ();
    vga_timing_if #(.X_W(4), .Y_W(3), .FRAME_W(2))  bus2 ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(D1), .X_W(4), .Y_W(3), .FRAME_W(16)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(D2), .X_W(4), .Y_W(3), .FRAME_W(2)
    ) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

    // Reference model: count enabled clocks and emitted pixels; position follows from the pixel count
    int   k1, n1, base1;
    logic tick1;
    int   k2, n2, base2;
    logic tick2;

    function automatic int lin_of(input int n);
        return (FT - 1 + n) % FT;
    endfunction
    function automatic int frames_of(input int n);
        return (n == 0) ? 0 : ((n - 1) / FT + 1);
    endfunction
    function automatic int m_x(input int n);
        return lin_of(n) % HT;
    endfunction
    function automatic int m_y(input int n);
        return lin_of(n) / HT;
    endfunction
    function automatic logic m_act(input int n);
        return (m_x(n) < HA) && (m_y(n) < VA);
    endfunction
    function automatic logic m_hs(input int n);
        return (m_x(n) >= HA + HFP && m_x(n) < HA + HFP + HSY) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic m_vs(input int n);
        return (m_y(n) >= VA + VFP && m_y(n) < VA + VFP + VSY) ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1 <= 0; n1 <= 0; base1 <= 0; tick1 <= 1'b0;
        end else if (bus1.restart) begin
            base1 <= (base1 + frames_of(n1)) % 65536;
            k1 <= 0; n1 <= 0; tick1 <= 1'b0;
        end else if (bus1.en) begin
            k1 <= k1 + 1;
            tick1 <= (((k1 + 1) % D1) == D1 - 1);
            if (((k1 + 1) % D1) == D1 - 1) n1 <= n1 + 1;
        end else begin
            tick1 <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k2 <= 0; n2 <= 0; base2 <= 0; tick2 <= 1'b0;
        end else if (bus2.restart) begin
            base2 <= (base2 + frames_of(n2)) % 4;
            k2 <= 0; n2 <= 0; tick2 <= 1'b0;
        end else if (bus2.en) begin
            k2 <= k2 + 1;
            tick2 <= (((k2 + 1) % D2) == D2 - 1);
            if (((k2 + 1) % D2) == D2 - 1) n2 <= n2 + 1;
        end else begin
            tick2 <= 1'b0;
        end
    end

    task automatic test_reset;
        bus1.en = 1'b0; bus1.restart = 1'b0;
        bus2.en = 1'b0; bus2.restart = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus1.x !== 4'd14 || bus1.y !== 3'd7 || bus1.active !== 1'b0 || bus1.hsync !== 1'b1 ||
            bus1.vsync !== 1'b1 || bus1.pix_en !== 1'b0 || bus1.line_start !== 1'b0 ||
            bus1.frame_start !== 1'b0 || bus1.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_dut1: got x=%0d y=%0d act=%b hs=%b vs=%b pe=%b ls=%b fs=%b fc=%0d, want 14 7 0 1 1 0 0 0 0",
                     bus1.x, bus1.y, bus1.active, bus1.hsync, bus1.vsync, bus1.pix_en,
                     bus1.line_start, bus1.frame_start, bus1.frame_cnt);
        end
        checks++;
        if (bus2.x !== 4'd14 || bus2.y !== 3'd7 || bus2.pix_en !== 1'b0 || bus2.frame_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_dut2: got x=%0d y=%0d pe=%b fc=%0d, want 14 7 0 0",
                     bus2.x, bus2.y, bus2.pix_en, bus2.frame_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.x !== 4'd14 || bus1.pix_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got x=%0d pe=%b, want 14 0", bus1.x, bus1.pix_en);
        end
    endtask

    task automatic test_first_pixel;
        int cnt;
        int last_y;
        bus1.en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.pix_en !== 1'b1 || bus1.x !== 4'd0 || bus1.y !== 3'd0 || bus1.active !== 1'b1 ||
            bus1.line_start !== 1'b1 || bus1.frame_start !== 1'b1 || bus1.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL first_pixel: got pe=%b x=%0d y=%0d act=%b ls=%b fs=%b fc=%0d, want 1 0 0 1 1 1 1",
                     bus1.pix_en, bus1.x, bus1.y, bus1.active, bus1.line_start,
                     bus1.frame_start, bus1.frame_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus1.pix_en !== 1'b0 || bus1.frame_start !== 1'b0 || bus1.line_start !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: got pe=%b ls=%b fs=%b, want 0 0 0",
                     bus1.pix_en, bus1.line_start, bus1.frame_start);
        end
        cnt = 1;
        last_y = -1;
        while (cnt < 1000) begin
            last_y = int'(bus1.y);
            @(negedge clk);
            cnt++;
            if (bus1.frame_start === 1'b1) break;
        end
        checks++;
        if (cnt != 240) begin
            errors++;
            $display("FAIL frame_period: got %0d clk, want 240", cnt);
        end
        checks++;
        if (last_y != VT - 1 || bus1.y !== 3'd0) begin
            errors++;
            $display("FAIL y_wrap: got y %0d -> %0d, want 7 -> 0", last_y, bus1.y);
        end
    endtask

    task automatic test_scan;
        int c_pe, c_ls, c_fs, c_act, c_hs, c_vs;
        c_pe = 0; c_ls = 0; c_fs = 0; c_act = 0; c_hs = 0; c_vs = 0;
        for (int i = 0; i < 240; i++) begin
            if (i > 0) @(negedge clk);
            c_pe  += int'(bus1.pix_en);
            c_ls  += int'(bus1.line_start);
            c_fs  += int'(bus1.frame_start);
            c_act += int'(bus1.active);
            c_hs  += int'(!bus1.hsync);
            c_vs  += int'(!bus1.vsync);
            checks++;
            if (int'(bus1.x) != m_x(n1) || int'(bus1.y) != m_y(n1) || bus1.active !== m_act(n1) ||
                bus1.hsync !== m_hs(n1) || bus1.vsync !== m_vs(n1)) begin
                errors++;
                $display("FAIL scan_pos: got x=%0d y=%0d act=%b hs=%b vs=%b, want %0d %0d %b %b %b",
                         bus1.x, bus1.y, bus1.active, bus1.hsync, bus1.vsync,
                         m_x(n1), m_y(n1), m_act(n1), m_hs(n1), m_vs(n1));
            end
        end
        checks++;
        if (c_pe != 120 || c_ls != 8 || c_fs != 1) begin
            errors++;
            $display("FAIL scan_strobes: got pe=%0d ls=%0d fs=%0d, want 120 8 1", c_pe, c_ls, c_fs);
        end
        checks++;
        if (c_act != 64 || c_hs != 48 || c_vs != 60) begin
            errors++;
            $display("FAIL scan_windows: got act=%0d hs_low=%0d vs_low=%0d clk, want 64 48 60",
                     c_act, c_hs, c_vs);
        end
    endtask

    task automatic test_en_freeze;
        int   guard;
        logic [15:0] fc_hold;
        guard = 0;
        while (!(bus1.pix_en === 1'b1 && bus1.x === 4'd5 && bus1.y === 3'd2) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL freeze_find: got no pixel (5,2) within 500 clk, want one");
        end
        fc_hold = bus1.frame_cnt;
        bus1.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (bus1.x !== 4'd5 || bus1.y !== 3'd2 || bus1.pix_en !== 1'b0 || bus1.line_start !== 1'b0 ||
                bus1.frame_start !== 1'b0 || bus1.frame_cnt !== fc_hold || bus1.active !== 1'b1) begin
                errors++;
                $display("FAIL freeze_hold: got x=%0d y=%0d pe=%b ls=%b fs=%b fc=%0d act=%b, want 5 2 0 0 0 %0d 1",
                         bus1.x, bus1.y, bus1.pix_en, bus1.line_start, bus1.frame_start,
                         bus1.frame_cnt, bus1.active, fc_hold);
            end
        end
        bus1.en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.pix_en !== 1'b0 || bus1.x !== 4'd5) begin
            errors++;
            $display("FAIL resume_phase: got pe=%b x=%0d, want 0 5", bus1.pix_en, bus1.x);
        end
        @(negedge clk);
        checks++;
        if (bus1.pix_en !== 1'b1 || bus1.x !== 4'd6 || bus1.y !== 3'd2) begin
            errors++;
            $display("FAIL resume_pixel: got pe=%b x=%0d y=%0d, want 1 6 2", bus1.pix_en, bus1.x, bus1.y);
        end
    endtask

    task automatic test_restart;
        int guard;
        logic [15:0] fc_hold;
        guard = 0;
        while (!(bus1.pix_en === 1'b1 && bus1.x === 4'd12 && bus1.y === 3'd6) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL restart_find: got no pixel (12,6) within 500 clk, want one");
        end
        @(negedge clk);
        fc_hold = bus1.frame_cnt;
        bus1.restart = 1'b1;
        @(negedge clk);
        bus1.restart = 1'b0;
        checks++;
        if (bus1.x !== 4'd14 || bus1.y !== 3'd7 || bus1.hsync !== 1'b1 || bus1.vsync !== 1'b1 ||
            bus1.active !== 1'b0 || bus1.pix_en !== 1'b0 || bus1.frame_cnt !== fc_hold) begin
            errors++;
            $display("FAIL restart_load: got x=%0d y=%0d hs=%b vs=%b act=%b pe=%b fc=%0d, want 14 7 1 1 0 0 %0d",
                     bus1.x, bus1.y, bus1.hsync, bus1.vsync, bus1.active, bus1.pix_en,
                     bus1.frame_cnt, fc_hold);
        end
        @(negedge clk);
        checks++;
        if (bus1.pix_en !== 1'b1 || bus1.x !== 4'd0 || bus1.y !== 3'd0 || bus1.frame_start !== 1'b1 ||
            bus1.frame_cnt !== fc_hold + 16'd1) begin
            errors++;
            $display("FAIL restart_resume: got pe=%b x=%0d y=%0d fs=%b fc=%0d, want 1 0 0 1 %0d",
                     bus1.pix_en, bus1.x, bus1.y, bus1.frame_start, bus1.frame_cnt, fc_hold + 16'd1);
        end
    endtask

    task automatic test_frame_wrap;
        int seen[$];
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        int guard;
        int pe_bad;
        guard = 0;
        pe_bad = 0;
        bus2.en = 1'b1;
        while (seen.size() < 5 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (bus2.pix_en !== 1'b1) pe_bad++;
            if (bus2.frame_start === 1'b1) seen.push_back(int'(bus2.frame_cnt));
        end
        bus2.en = 1'b0;
        checks++;
        if (pe_bad != 0 || guard != 4 * FT + 1) begin
            errors++;
            $display("FAIL clkdiv1: got %0d clk without pix_en, 5 frames in %0d clk, want 0 and %0d",
                     pe_bad, guard, 4 * FT + 1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= seen.size() || seen[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL frame_cnt_wrap[%0d]: got %0d, want %0d", i,
                         (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            checks++;
            if (int'(bus1.x) != m_x(n1) || int'(bus1.y) != m_y(n1) || bus1.active !== m_act(n1) ||
                bus1.hsync !== m_hs(n1) || bus1.vsync !== m_vs(n1) || bus1.pix_en !== tick1 ||
                bus1.line_start !== (tick1 && m_x(n1) == 0) ||
                bus1.frame_start !== (tick1 && lin_of(n1) == 0) ||
                int'(bus1.frame_cnt) != (base1 + frames_of(n1)) % 65536) begin
                errors++;
                $display("FAIL random[%0d]: got x=%0d y=%0d act=%b hs=%b vs=%b pe=%b ls=%b fs=%b fc=%0d, want %0d %0d %b %b %b %b %b %b %0d",
                         i, bus1.x, bus1.y, bus1.active, bus1.hsync, bus1.vsync, bus1.pix_en,
                         bus1.line_start, bus1.frame_start, bus1.frame_cnt,
                         m_x(n1), m_y(n1), m_act(n1), m_hs(n1), m_vs(n1), tick1,
                         tick1 && m_x(n1) == 0, tick1 && lin_of(n1) == 0,
                         (base1 + frames_of(n1)) % 65536);
            end
            bus1.en      = ($urandom_range(0, 9) < 7);
            bus1.restart = ($urandom_range(0, 49) == 0);
        end
        bus1.restart = 1'b0;
        bus1.en      = 1'b1;
    endtask

    task automatic test_async_reset;
        repeat (37) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.x !== 4'd14 || bus1.y !== 3'd7 || bus1.frame_cnt !== 16'd0 || bus1.pix_en !== 1'b0 ||
            bus1.line_start !== 1'b0 || bus1.frame_start !== 1'b0 || bus1.hsync !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got x=%0d y=%0d fc=%0d pe=%b ls=%b fs=%b hs=%b, want 14 7 0 0 0 0 1",
                     bus1.x, bus1.y, bus1.frame_cnt, bus1.pix_en, bus1.line_start,
                     bus1.frame_start, bus1.hsync);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.x !== 4'd0 || bus1.y !== 3'd0 || bus1.frame_start !== 1'b1 || bus1.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_pixel: got x=%0d y=%0d fs=%b fc=%0d, want 0 0 1 1",
                     bus1.x, bus1.y, bus1.frame_start, bus1.frame_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_first_pixel;
        test_scan;
        test_en_freeze;
        test_restart;
        test_frame_wrap;
        test_random;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
